program_loader: RTL and testbench
=================================

# program_loader

Byte-serial boot loader that sits upstream of the RISC-V core and its instruction memory. It receives a framed program image over a valid/ready byte stream and assembles little-endian 32-bit instructions. It writes them into instruction memory at consecutive word addresses and holds the core in reset until a complete frame with a correct checksum has been loaded. On any framing or checksum failure the core stays in reset until the next `reset`.

## Interface
Parameters:
- `MAX_WORDS`, 16: maximum instruction words per frame; larger length field is an error.
- `BASE_ADDR`, 64'd0: byte address of the first instruction written.
- `TIMEOUT_CYCLES`, 1000: inter-byte idle limit; used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte this cycle.
- `im_we` output 1: instruction memory write strobe, one cycle per word.
- `im_addr` output 64: byte address of the word being written.
- `im_wdata` output 32: instruction word being written.
- `core_reset` output 1: reset to the core; high until a successful load.
- `done` output 1: frame loaded and checksum matched.
- `error` output 1: frame rejected.
- `words_loaded` output 16: count of words written in the current frame.

## Operation
- Frame layout: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then 4·N payload bytes (each word little-endian), then one checksum byte.
- The expected checksum is the XOR of every byte before the checksum byte, including both length bytes.
- A byte is accepted when `in_valid & in_ready` is true at a rising `clk` edge. `in_ready` is decoded from state.
- FSM states and transitions:
  - S_LEN_LO: accept byte → S_LEN_HI.
  - S_LEN_HI: accept byte. If N > MAX_WORDS → S_ERROR. If N == 0 → S_CKSUM. Otherwise → S_DATA.
  - S_DATA: accept bytes into a 32-bit shift register; the byte index wraps 0..3. On the 4th byte → S_WRITE.
  - S_WRITE: `im_we`=1 for this cycle only; `in_ready`=0.
    - `im_addr` = BASE_ADDR + 4·`words_loaded`; `im_wdata` = assembled word.
    - `words_loaded` increments at the end of the cycle.
    - Next state is S_CKSUM if `words_loaded`+1 == N, else S_DATA.
  - S_CKSUM: accept byte. Match → S_DONE, mismatch → S_ERROR.
  - S_DONE: `done`=1, `core_reset`=0, `in_ready`=0. Terminal until `reset`.
  - S_ERROR: `error`=1, `core_reset`=1, `in_ready`=0. Terminal until `reset`.
- `in_ready`=1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CKSUM.
- Address arithmetic is 64-bit and unsigned; no wrap occurs within MAX_WORDS.
- `done` and `error` are never both high.
- No `im_we` pulse occurs after S_ERROR is entered, or at all for N == 0.

## Timing
- Reset values (applied asynchronously while `reset` is high):
  - State S_LEN_LO, so `in_ready`=1.
  - `im_we`=0, `im_addr`=BASE_ADDR, `im_wdata`=0.
  - `core_reset`=1, `done`=0, `error`=0, `words_loaded`=0.
  - Checksum accumulator and byte index are 0.
- Word write: `im_we` is high in the cycle after the 4th byte of a word is accepted. `im_addr`/`im_wdata` are registered and stable during that cycle.
- Maximum throughput is 5 cycles per word (4 accept cycles plus 1 write cycle).
- Checksum byte accepted at edge k → `done`/`error` high and `core_reset` at its final value from edge k+1.
- Gaps in `in_valid` stall the FSM with no state change. Holding `in_valid` during `in_ready`=0 loses no byte.
- Reset asserted mid-frame aborts the load immediately. The partial instruction memory contents are not cleared, and the next frame restarts from S_LEN_LO.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - An idle counter runs in S_LEN_HI, S_DATA and S_CKSUM.
  - It clears on every accepted byte and on entry to those states.
  - Reaching TIMEOUT_CYCLES → S_ERROR on the next edge.
  - S_LEN_LO (no frame started) never times out.
- `LOADER_TIMEOUT_EN` undefined: no counter exists, and the loader waits indefinitely for the next byte.

## Test plan
- Nominal two-word load:
  - Stimulus: send 02 00 93 00 50 00 13 01 A0 00 73.
  - Response: `im_we` pulses write addr 0 / 0x00500093 and addr 4 / 0x00A00113; `words_loaded`=2; then `done`=1, `core_reset`=0, `error`=0.
- Bad checksum: the same frame with final byte 74 → both words are written, then `error`=1, `core_reset`=1, `done`=0.
- Oversize length: with MAX_WORDS=16, send 11 00 → `error`=1 one cycle after the 2nd byte; no `im_we` ever; `in_ready`=0 afterwards.
- Empty frame: send 00 00 00 → no `im_we`; `done`=1 and `core_reset`=0 one cycle after the 3rd byte.
- Backpressure and reset:
  - Nominal frame with `in_valid` toggling every other cycle → identical writes and result; `in_ready`=0 exactly in each write cycle.
  - Assert `reset` after 6 bytes → all outputs return to reset values; a following nominal frame loads correctly.
- Timeout (`LOADER_TIMEOUT_EN`, TIMEOUT_CYCLES=1000):
  - Send 02 00 93 then idle → `error`=1 after 1000 idle cycles.
  - Without the macro, the same stimulus leaves `error`=0 and `in_ready`=1 indefinitely.

Source files
------------

// File: rtl/program_loader.sv
// Byte-serial boot loader: receives a framed little-endian program image over
// a valid/ready byte stream, writes 32-bit words to instruction memory and
// releases the core reset only after a frame with a matching checksum.
//
// Frame: LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum of all prior bytes.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_data     input byte stream; in_ready accepts a byte
//   im_we/im_addr/im_wdata  instruction memory write port (one cycle per word)
//   core_reset           held high until a successful load
//   done / error         frame accepted / frame rejected (terminal)
//   words_loaded         words written in the current frame
//
// Optional feature: define LOADER_TIMEOUT_EN to abort a started frame after
// TIMEOUT_CYCLES idle cycles between bytes.
module program_loader #(
   parameter int          MAX_WORDS      = 16,
   parameter logic [63:0] BASE_ADDR      = 64'd0,
   parameter int          TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_we,
   output logic [63:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        core_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CKSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   state_t      state;
   state_t      state_nx;
   logic [15:0] len_q;
   logic [7:0]  cksum_q;
   logic [1:0]  idx_q;
   logic        accept;
   logic [15:0] len_full;
   logic        timeout;

   assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CKSUM);
   assign accept   = in_valid && in_ready;
   assign len_full = {in_data, len_q[7:0]};

`ifdef LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_q;
   logic          timed;

   // S_LEN_LO is excluded: an idle line before a frame is not a fault.
   assign timed   = (state == S_LEN_HI) || (state == S_DATA) ||
                    (state == S_CKSUM);
   assign timeout = timed && !accept && (idle_q == TW'(TIMEOUT_CYCLES));

   // Any non-timed state (including S_WRITE) clears the counter, so each
   // entry into a timed state starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idle_q <= '0;
      else if (!timed || accept)
         idle_q <= '0;
      else
         idle_q <= idle_q + TW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      im_we      = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      core_reset = 1'b1;
      unique case (state)
         S_LEN_LO: begin
            if (accept)
               state_nx = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               if (len_full > MAX_N)
                  state_nx = S_ERROR;
               else if (len_full == 16'd0)
                  state_nx = S_CKSUM;
               else
                  state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && idx_q == 2'd3)
               state_nx = S_WRITE;
         end
         S_WRITE: begin
            im_we = 1'b1;
            if (words_loaded + 16'd1 == len_q)
               state_nx = S_CKSUM;
            else
               state_nx = S_DATA;
         end
         S_CKSUM: begin
            if (accept)
               state_nx = (in_data == cksum_q) ? S_DONE : S_ERROR;
         end
         S_DONE: begin
            done       = 1'b1;
            core_reset = 1'b0;
         end
         S_ERROR: begin
            error = 1'b1;
         end
         default: state_nx = S_ERROR;
      endcase
      if (timeout)
         state_nx = S_ERROR;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_LEN_LO;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q        <= '0;
         cksum_q      <= '0;
         idx_q        <= '0;
         im_addr      <= BASE_ADDR;
         im_wdata     <= '0;
         words_loaded <= '0;
      end else begin
         if (accept && state != S_CKSUM)
            cksum_q <= cksum_q ^ in_data;
         if (accept && state == S_LEN_LO)
            len_q[7:0] <= in_data;
         if (accept && state == S_LEN_HI)
            len_q[15:8] <= in_data;
         // First byte ends up in bits [7:0]: little-endian assembly.
         if (accept && state == S_DATA) begin
            im_wdata <= {in_data, im_wdata[31:8]};
            idx_q    <= idx_q + 2'd1;
            if (idx_q == 2'd3)
               im_addr <= BASE_ADDR + {46'd0, words_loaded, 2'b00};
         end
         if (state == S_WRITE)
            words_loaded <= words_loaded + 16'd1;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of frames with expected writes
// and outcome, plus sequences for latency, mid-frame reset and idle line.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [63:0] im_addr;
   logic [31:0] im_wdata;
   logic        core_reset;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   program_loader dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .core_reset   (core_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [95:0] wlog[$];

   typedef struct packed {
      logic [3:0]  nb;
      logic [95:0] bytes;
      logic [1:0]  nw;
      logic [63:0] words;
      logic        d;
      logic        e;
      logic        gap;
   } vec_t;

   vec_t tab[8];

   always @(negedge clk) begin
      if (im_we) begin
         wlog.push_back({im_addr, im_wdata});
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_write: got %b want 0", in_ready);
         end
      end
      if (done === 1'b1 && error === 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_and_error: both high");
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic gap);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1 ok = 1'b1;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_wait: byte %h never accepted", b);
      end
      in_valid = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_check(input vec_t v, input int id);
      logic [63:0] exp_w;
      wlog.delete();
      for (int i = 0; i < int'(v.nb); i++)
         send_byte(v.bytes[95-i*8 -: 8], v.gap);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d done", id), 64'(done), 64'(v.d));
      chk($sformatf("v%0d error", id), 64'(error), 64'(v.e));
      chk($sformatf("v%0d core_reset", id), 64'(core_reset), 64'(!v.d));
      chk($sformatf("v%0d in_ready", id), 64'(in_ready), 64'd0);
      chk($sformatf("v%0d words", id), 64'(words_loaded), 64'(v.nw));
      chk($sformatf("v%0d nwrites", id), 64'(wlog.size()), 64'(v.nw));
      for (int j = 0; j < int'(v.nw) && j < wlog.size(); j++) begin
         exp_w = (j == 0) ? {32'd0, v.words[63:32]} : {32'd0, v.words[31:0]};
         chk($sformatf("v%0d addr%0d", id, j), wlog[j][95:32], 64'(4 * j));
         chk($sformatf("v%0d data%0d", id, j), {32'd0, wlog[j][31:0]}, exp_w);
      end
   endtask

   initial begin
      tab[0] = '{4'd11, 96'h02_00_93_00_50_00_13_01_A0_00_73_00, 2'd2,
                 64'h00500093_00A00113, 1'b1, 1'b0, 1'b0};
      tab[1] = '{4'd11, 96'h02_00_93_00_50_00_13_01_A0_00_74_00, 2'd2,
                 64'h00500093_00A00113, 1'b0, 1'b1, 1'b0};
      tab[2] = '{4'd2, 96'h11_00_00_00_00_00_00_00_00_00_00_00, 2'd0,
                 64'd0, 1'b0, 1'b1, 1'b0};
      tab[3] = '{4'd3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 2'd0,
                 64'd0, 1'b1, 1'b0, 1'b0};
      tab[4] = '{4'd7, 96'h01_00_EF_BE_AD_DE_23_00_00_00_00_00, 2'd1,
                 64'hDEADBEEF_00000000, 1'b1, 1'b0, 1'b0};
      tab[5] = '{4'd2, 96'h00_01_00_00_00_00_00_00_00_00_00_00, 2'd0,
                 64'd0, 1'b0, 1'b1, 1'b0};
      tab[6] = '{4'd7, 96'h01_00_EF_BE_AD_DE_24_00_00_00_00_00, 2'd1,
                 64'hDEADBEEF_00000000, 1'b0, 1'b1, 1'b0};
      tab[7] = '{4'd11, 96'h02_00_93_00_50_00_13_01_A0_00_73_00, 2'd2,
                 64'h00500093_00A00113, 1'b1, 1'b0, 1'b1};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst im_we", 64'(im_we), 64'd0);
      chk("rst im_addr", im_addr, 64'd0);
      chk("rst im_wdata", 64'(im_wdata), 64'd0);
      chk("rst core_reset", 64'(core_reset), 64'd1);
      chk("rst done", 64'(done), 64'd0);
      chk("rst error", 64'(error), 64'd0);
      chk("rst words", 64'(words_loaded), 64'd0);

      for (int k = 0; k < 8; k++) begin
         do_reset();
         send_check(tab[k], k);
      end

      // Oversize length: error from the edge after LEN_HI.
      do_reset();
      send_byte(8'h11, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("big error_lat", 64'(error), 64'd1);
      chk("big in_ready", 64'(in_ready), 64'd0);

      // Empty frame: done from the edge after the checksum byte.
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("empty done_early", 64'(done), 64'd0);
      send_byte(8'h00, 1'b0);
      chk("empty done_lat", 64'(done), 64'd1);
      chk("empty core_reset", 64'(core_reset), 64'd0);

      // Write latency, then asynchronous reset mid-frame.
      do_reset();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h50, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("wr im_we", 64'(im_we), 64'd1);
      chk("wr addr", im_addr, 64'd0);
      chk("wr data", 64'(im_wdata), 64'h00500093);
      @(posedge clk);
      #1;
      chk("wr im_we_off", 64'(im_we), 64'd0);
      chk("wr words", 64'(words_loaded), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst words", 64'(words_loaded), 64'd0);
      chk("arst wdata", 64'(im_wdata), 64'd0);
      chk("arst in_ready", 64'(in_ready), 64'd1);
      chk("arst core_reset", 64'(core_reset), 64'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      send_check(tab[0], 100);

      // Maximum-length frame, bench-computed checksum.
      begin
         logic [7:0]  ck;
         logic [31:0] w;
         do_reset();
         wlog.delete();
         ck = 8'h10;
         send_byte(8'h10, 1'b0);
         send_byte(8'h00, 1'b0);
         for (int j = 0; j < 16; j++)
            for (int b = 0; b < 4; b++) begin
               ck = ck ^ 8'(4 * j + b);
               send_byte(8'(4 * j + b), 1'b0);
            end
         send_byte(ck, 1'b0);
         @(posedge clk);
         #1;
         chk("max done", 64'(done), 64'd1);
         chk("max words", 64'(words_loaded), 64'd16);
         chk("max nwrites", 64'(wlog.size()), 64'd16);
         for (int j = 0; j < 16 && j < wlog.size(); j++) begin
            w = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
            chk($sformatf("max addr%0d", j), wlog[j][95:32], 64'(4 * j));
            chk($sformatf("max data%0d", j), {32'd0, wlog[j][31:0]},
                {32'd0, w});
         end
      end

      // Idle line after a partial frame.
      do_reset();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h93, 1'b0);
      repeat (1100) @(posedge clk);
      #1;
`ifdef LOADER_TIMEOUT_EN
      chk("idle error", 64'(error), 64'd1);
      chk("idle in_ready", 64'(in_ready), 64'd0);
`else
      chk("idle error", 64'(error), 64'd0);
      chk("idle in_ready", 64'(in_ready), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
